// File: rtl/irtcv_rxfe.sv
// IR transceiver receive front-end: input synchroniser, glitch filter,
// rising-edge detect, carrier period measurement and envelope recovery.
//
// Envelope FSM states
//   state    | meaning
//   ST_IDLE  | no carrier activity; ir_env low (or follows ir_filt in bypass)
//   ST_MARK  | carrier present; ir_env high, ecnt counts down to expiry
module irtcv_rxfe #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int ENV_W       = 12,
  parameter int PER_W       = 12
) (
  input  logic              irtcv_clk,
  input  logic              irtcv_rst_async,
  input  logic              rxfe_en,
  input  logic              rxfe_inv,
  input  logic [FILT_W-1:0] rxfe_filt_len,
  input  logic [ENV_W-1:0]  rxfe_env_to,
  input  logic              ir_raw,
  output logic              ir_filt,
  output logic              ir_rise,
  output logic              ir_env,
  output logic [PER_W-1:0]  per_dat,
  output logic              per_vld,
  output logic              per_ovf
);

  typedef enum logic {ST_IDLE, ST_MARK} env_state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      fcnt_q, fcnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_dly_q, filt_dly_d;
  logic                   rise_q, rise_d;
  logic [PER_W-1:0]       pcnt_q, pcnt_d;
  logic                   armed_q, armed_d;
  logic [PER_W-1:0]       per_dat_q, per_dat_d;
  logic                   per_vld_q, per_vld_d;
  logic                   per_ovf_q, per_ovf_d;
  env_state_t             env_state_q, env_state_d;
  logic [ENV_W-1:0]       ecnt_q, ecnt_d;
  logic                   env_q, env_d;

  logic s_q;
  logic pcnt_sat;

  assign s_q      = sync_q[SYNC_STAGES-1];
  assign pcnt_sat = &pcnt_q;

  // Synchroniser, glitch filter and registered rising-edge detect.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ir_raw ^ rxfe_inv};
    filt_d     = filt_q;
    fcnt_d     = '0;
    filt_dly_d = filt_q;
    rise_d     = filt_q & ~filt_dly_q;
    if (s_q != filt_q) begin
      // Compare against the live length so a mid-count change applies at once.
      if (fcnt_q >= rxfe_filt_len) begin
        filt_d = ~filt_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FILT_W'(1);
      end
    end
    if (!rxfe_en) begin
      sync_d     = '0;
      filt_d     = 1'b0;
      fcnt_d     = '0;
      filt_dly_d = 1'b0;
      rise_d     = 1'b0;
    end
  end

  // Carrier period measurement between successive ir_rise pulses.
  always_comb begin
    pcnt_d    = pcnt_sat ? pcnt_q : pcnt_q + PER_W'(1);
    armed_d   = armed_q;
    per_dat_d = per_dat_q;
    per_vld_d = 1'b0;
    per_ovf_d = per_ovf_q | pcnt_sat;
    if (rise_q) begin
      // A saturated count is not a valid period; the rise only re-arms.
      if (armed_q && !pcnt_sat) begin
        per_dat_d = pcnt_q;
        per_vld_d = 1'b1;
        per_ovf_d = 1'b0;
      end
      pcnt_d  = PER_W'(1);
      armed_d = 1'b1;
    end
    if (!rxfe_en) begin
      pcnt_d    = '0;
      armed_d   = 1'b0;
      per_dat_d = '0;
      per_vld_d = 1'b0;
      per_ovf_d = 1'b0;
    end
  end

  // Envelope FSM next-state and output; timeout of zero bypasses it.
  always_comb begin
    env_state_d = env_state_q;
    ecnt_d      = ecnt_q;
    env_d       = env_q;
    if (rxfe_env_to == '0) begin
      env_state_d = ST_IDLE;
      ecnt_d      = '0;
      env_d       = filt_q;
    end else begin
      case (env_state_q)
        ST_IDLE: begin
          env_d  = 1'b0;
          ecnt_d = '0;
          if (rise_q) begin
            env_state_d = ST_MARK;
            env_d       = 1'b1;
            ecnt_d      = rxfe_env_to;
          end
        end
        ST_MARK: begin
          env_d = 1'b1;
          // A rise in the expiry cycle reloads and keeps the mark alive.
          if (rise_q) begin
            ecnt_d = rxfe_env_to;
          end else if (ecnt_q <= ENV_W'(1)) begin
            env_state_d = ST_IDLE;
            env_d       = 1'b0;
            ecnt_d      = '0;
          end else begin
            ecnt_d = ecnt_q - ENV_W'(1);
          end
        end
        default: begin
          env_state_d = ST_IDLE;
          env_d       = 1'b0;
          ecnt_d      = '0;
        end
      endcase
    end
    if (!rxfe_en) begin
      env_state_d = ST_IDLE;
      ecnt_d      = '0;
      env_d       = 1'b0;
    end
  end

  // State registers; async reset clears everything.
  always_ff @(posedge irtcv_clk or posedge irtcv_rst_async) begin
    if (irtcv_rst_async) begin
      sync_q      <= '0;
      fcnt_q      <= '0;
      filt_q      <= 1'b0;
      filt_dly_q  <= 1'b0;
      rise_q      <= 1'b0;
      pcnt_q      <= '0;
      armed_q     <= 1'b0;
      per_dat_q   <= '0;
      per_vld_q   <= 1'b0;
      per_ovf_q   <= 1'b0;
      env_state_q <= ST_IDLE;
      ecnt_q      <= '0;
      env_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      fcnt_q      <= fcnt_d;
      filt_q      <= filt_d;
      filt_dly_q  <= filt_dly_d;
      rise_q      <= rise_d;
      pcnt_q      <= pcnt_d;
      armed_q     <= armed_d;
      per_dat_q   <= per_dat_d;
      per_vld_q   <= per_vld_d;
      per_ovf_q   <= per_ovf_d;
      env_state_q <= env_state_d;
      ecnt_q      <= ecnt_d;
      env_q       <= env_d;
    end
  end

  assign ir_filt = filt_q;
  assign ir_rise = rise_q;
  assign ir_env  = env_q;
  assign per_dat = per_dat_q;
  assign per_vld = per_vld_q;
  assign per_ovf = per_ovf_q;

endmodule

// File: tb/tb_irtcv_rxfe.sv
// Directed bench for irtcv_rxfe (PER_W=8 so saturation is reachable quickly).
module tb_irtcv_rxfe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        inv = 1'b0;
  logic [3:0]  flen = 4'd3;
  logic [11:0] env_to = 12'd0;
  logic        raw = 1'b0;

  logic        ir_filt, ir_rise, ir_env, per_vld, per_ovf;
  logic [7:0]  per_dat;

  int n_pass = 0;
  int n_total = 0;

  irtcv_rxfe #(.SYNC_STAGES(2), .FILT_W(4), .ENV_W(12), .PER_W(8)) dut (
    .irtcv_clk       (clk),
    .irtcv_rst_async (rst),
    .rxfe_en         (en),
    .rxfe_inv        (inv),
    .rxfe_filt_len   (flen),
    .rxfe_env_to     (env_to),
    .ir_raw          (raw),
    .ir_filt         (ir_filt),
    .ir_rise         (ir_rise),
    .ir_env          (ir_env),
    .per_dat         (per_dat),
    .per_vld         (per_vld),
    .per_ovf         (per_ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [12:0] outs();
    return {ir_filt, ir_rise, ir_env, per_vld, per_ovf, per_dat};
  endfunction

  task automatic en_pulse();
    raw = 1'b0;
    en  = 1'b0;
    clk_n(1);
    en  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; raw = 1'b0;
    clk_n(3);
    n_total++;
    if (outs() !== 13'd0) $display("FAIL reset_state: got %h want 0", outs());
    else n_pass++;
    rst = 1'b0; raw = 1'b1;
    clk_n(10);
    n_total++;
    if (outs() !== 13'd0) $display("FAIL disabled_hold: got %h want 0", outs());
    else n_pass++;
    raw = 1'b0; en = 1'b1;
    clk_n(5);
    n_total++;
    if (outs() !== 13'd0) $display("FAIL enable_idle: got %h want 0", outs());
    else n_pass++;
  endtask

  task automatic test_latency();
    logic ef, er;
    flen = 4'd3; env_to = 12'd0;
    raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      clk_n(1);
      ef = (k >= 6);
      er = (k == 7);
      n_total++;
      if (ir_filt !== ef) $display("FAIL lat_filt_k%0d: got %b want %b", k, ir_filt, ef);
      else n_pass++;
      n_total++;
      if (ir_rise !== er) $display("FAIL lat_rise_k%0d: got %b want %b", k, ir_rise, er);
      else n_pass++;
    end
    raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      clk_n(1);
      ef = (k < 6);
      n_total++;
      if (ir_filt !== ef) $display("FAIL lat_fall_k%0d: got %b want %b", k, ir_filt, ef);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int w;
    int bad;
    int first_bad;
    logic ef;
    flen = 4'd3;
    for (int t = 0; t < 3; t++) begin
      w = (t == 0) ? 1 : (t == 1) ? 3 : 4;
      bad = 0; first_bad = -1;
      for (int k = 0; k < 16; k++) begin
        raw = (k < w);
        clk_n(1);
        ef = (w == 4) && (k >= 5) && (k <= 8);
        if (ir_filt !== ef) begin
          bad++;
          if (first_bad < 0) first_bad = k;
        end
      end
      n_total++;
      if (bad != 0) $display("FAIL glitch_w%0d: %0d bad cycles (first %0d), want 0", w, bad, first_bad);
      else n_pass++;
    end
  endtask

  task automatic test_period();
    int vld_cnt = 0;
    int rise_cnt = 0;
    int first_vld = -1;
    flen = 4'd0; env_to = 12'd0;
    en_pulse();
    for (int c = 0; c < 110; c++) begin
      raw = (c < 100) && ((c % 20) < 10);
      clk_n(1);
      if (ir_rise) rise_cnt++;
      if (per_vld) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = c;
        n_total++;
        if (per_dat !== 8'd20) $display("FAIL period_dat_c%0d: got %0d want 20", c, per_dat);
        else n_pass++;
      end
    end
    n_total++;
    if (vld_cnt != 4) $display("FAIL period_vld_count: got %0d want 4", vld_cnt);
    else n_pass++;
    n_total++;
    if (rise_cnt != 5) $display("FAIL period_rise_count: got %0d want 5", rise_cnt);
    else n_pass++;
    n_total++;
    if (first_vld != 24) $display("FAIL period_first_vld: got cycle %0d want 24", first_vld);
    else n_pass++;
    n_total++;
    if (per_ovf !== 1'b0) $display("FAIL period_ovf: got %b want 0", per_ovf);
    else n_pass++;
  endtask

  task automatic test_envelope();
    int bad = 0;
    int first_bad = -1;
    logic ee;
    logic rh [0:59];
    flen = 4'd0;
    env_to = 12'd30;
    for (int c = 0; c < 240; c++) begin
      raw = (c < 200) && ((c % 20) < 10);
      clk_n(1);
      ee = (c >= 4) && (c <= 213);
      if (ir_env !== ee) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL env_profile: %0d bad cycles (first %0d), want 0", bad, first_bad);
    else n_pass++;

    env_to = 12'd0;
    bad = 0; first_bad = -1;
    for (int c = 0; c < 60; c++) begin
      rh[c] = (c < 50) && (((c % 7) == 0) || ((c % 11) < 3));
      raw = rh[c];
      clk_n(1);
      ee = (c >= 3) ? rh[c-3] : 1'b0;
      if (ir_env !== ee) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL env_bypass: %0d bad cycles (first %0d), want 0", bad, first_bad);
    else n_pass++;
    raw = 1'b0;
    clk_n(5);
  endtask

  task automatic test_overflow();
    int vld_cnt = 0;
    int vld_c = -1;
    logic [7:0] vld_dat = 8'd0;
    logic vld_ovf = 1'b1;
    logic ovf_299 = 1'b0;
    logic ovf_310 = 1'b0;
    flen = 4'd0; env_to = 12'd0;
    en_pulse();
    for (int c = 0; c < 360; c++) begin
      raw = (c < 10) || ((c >= 300) && (c < 310)) || ((c >= 320) && (c < 330));
      clk_n(1);
      if (c == 299) ovf_299 = per_ovf;
      if (c == 310) ovf_310 = per_ovf;
      if (per_vld) begin
        vld_cnt++;
        vld_c   = c;
        vld_dat = per_dat;
        vld_ovf = per_ovf;
      end
    end
    n_total++;
    if (ovf_299 !== 1'b1) $display("FAIL ovf_before_rise: got %b want 1", ovf_299);
    else n_pass++;
    n_total++;
    if (ovf_310 !== 1'b1) $display("FAIL ovf_after_sat_rise: got %b want 1", ovf_310);
    else n_pass++;
    n_total++;
    if (vld_cnt != 1) $display("FAIL ovf_vld_count: got %0d want 1", vld_cnt);
    else n_pass++;
    n_total++;
    if (vld_c != 324) $display("FAIL ovf_vld_cycle: got %0d want 324", vld_c);
    else n_pass++;
    n_total++;
    if (vld_dat !== 8'd20) $display("FAIL ovf_next_dat: got %0d want 20", vld_dat);
    else n_pass++;
    n_total++;
    if (vld_ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", vld_ovf);
    else n_pass++;
  endtask

  task automatic test_invert();
    flen = 4'd0; env_to = 12'd0;
    en_pulse();
    inv = 1'b1;
    clk_n(3);
    n_total++;
    if (ir_filt !== 1'b1) $display("FAIL invert_low_raw: got %b want 1", ir_filt);
    else n_pass++;
    raw = 1'b1;
    clk_n(3);
    n_total++;
    if (ir_filt !== 1'b0) $display("FAIL invert_high_raw: got %b want 0", ir_filt);
    else n_pass++;
    inv = 1'b0; raw = 1'b0;
    clk_n(5);
  endtask

  task automatic test_midreset();
    int rises;
    int vlds;
    logic any_out;
    logic env_seen;
    flen = 4'd0; env_to = 12'd30;
    en_pulse();
    raw = 1'b1; clk_n(10);
    raw = 1'b0; clk_n(1);
    n_total++;
    if (ir_env !== 1'b1) $display("FAIL env_before_rst: got %b want 1", ir_env);
    else n_pass++;

    rst = 1'b1;
    #1;
    n_total++;
    if (outs() !== 13'd0) $display("FAIL async_reset: got %h want 0", outs());
    else n_pass++;
    clk_n(1);
    rst = 1'b0;
    any_out = 1'b0;
    for (int c = 0; c < 40; c++) begin
      clk_n(1);
      any_out |= |outs();
    end
    n_total++;
    if (any_out !== 1'b0) $display("FAIL rst_release_quiet: got %b want 0", any_out);
    else n_pass++;

    rises = 0; vlds = 0; env_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      raw = (c < 10);
      clk_n(1);
      if (ir_rise) rises++;
      if (per_vld) vlds++;
      env_seen |= ir_env;
    end
    n_total++;
    if (rises != 1 || vlds != 0 || env_seen !== 1'b1)
      $display("FAIL rst_fresh_rise: rises %0d vlds %0d env %b want 1 0 1", rises, vlds, env_seen);
    else n_pass++;

    n_total++;
    if (ir_env !== 1'b1) $display("FAIL env_before_dis: got %b want 1", ir_env);
    else n_pass++;
    en = 1'b0;
    clk_n(1);
    n_total++;
    if (outs() !== 13'd0) $display("FAIL sync_disable: got %h want 0", outs());
    else n_pass++;
    any_out = 1'b0;
    for (int c = 0; c < 12; c++) begin
      raw = (c % 4) < 2;
      clk_n(1);
      any_out |= |outs();
    end
    raw = 1'b0; en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      clk_n(1);
      any_out |= |outs();
    end
    n_total++;
    if (any_out !== 1'b0) $display("FAIL dis_hold_quiet: got %b want 0", any_out);
    else n_pass++;

    rises = 0; vlds = 0; env_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      raw = (c < 10);
      clk_n(1);
      if (ir_rise) rises++;
      if (per_vld) vlds++;
      env_seen |= ir_env;
    end
    n_total++;
    if (rises != 1 || vlds != 0 || env_seen !== 1'b1)
      $display("FAIL en_fresh_rise: rises %0d vlds %0d env %b want 1 0 1", rises, vlds, env_seen);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_period();
    test_envelope();
    test_overflow();
    test_invert();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
